// File: rtl/multi_alarm_clock.sv
// BCD time-of-day clock with NUM_ALARMS independent alarms, snooze, stop and auto-timeout.
// Time and alarm registers are edited by rising edges of the debounced edit buttons.
module multi_alarm_clock #(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned NUM_ALARMS   = 4,
    parameter int unsigned RING_SECONDS = 60,
    parameter int unsigned SNOOZE_MIN   = 5,
    localparam int unsigned SW = $clog2(NUM_ALARMS + 1),
    localparam int unsigned IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [SW-1:0]         sel,
    input  logic [1:0]            edit_btns,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic                  snooze,
    input  logic                  stop,
    output logic [19:0]           disp_time,
    output logic                  alarm,
    output logic [IW-1:0]         alarm_id,
    output logic                  sec_tick
);

    localparam int unsigned PW        = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam int unsigned SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int unsigned RW        = $clog2(RING_SECONDS + 1);
    localparam int unsigned ZW        = $clog2(SNZ_TICKS + 1);

    typedef enum logic [1:0] {StIdle, StRing, StSnooze} state_e;

    logic [PW-1:0] pre_q, pre_d;
    logic [5:0]    hr_q, hr_d;
    logic [6:0]    min_q, min_d, sec_q, sec_d;
    logic [5:0]    al_hr_q [NUM_ALARMS];
    logic [5:0]    al_hr_d [NUM_ALARMS];
    logic [6:0]    al_min_q [NUM_ALARMS];
    logic [6:0]    al_min_d [NUM_ALARMS];
    logic [1:0]    edit_q;
    logic          snooze_q, stop_q;
    logic          win_q, win_d;
    state_e        state_q, state_d;
    logic [RW-1:0] ring_q, ring_d;
    logic [ZW-1:0] snz_q, snz_d;
    logic [IW-1:0] id_q, id_d;
    logic          alarm_q, alarm_d;

    logic [1:0]    edit_rise;
    logic          snooze_rise, stop_rise, sel_clock, clk_edit, match;
    logic [IW-1:0] view_idx, match_id;

    // {tens[2:0], ones[3:0]} counting 00..59
    function automatic logic [6:0] inc60(input logic [6:0] v);
        if (v[3:0] != 4'd9) return {v[6:4], v[3:0] + 4'd1};
        if (v[6:4] == 3'd5) return 7'd0;
        return {v[6:4] + 3'd1, 4'd0};
    endfunction

    function automatic logic [5:0] inc24(input logic [5:0] v);
        if (v == 6'h23) return 6'd0;
        if (v[3:0] != 4'd9) return {v[5:4], v[3:0] + 4'd1};
        return {v[5:4] + 2'd1, 4'd0};
    endfunction

    assign edit_rise   = edit_btns & ~edit_q;
    assign snooze_rise = snooze & ~snooze_q;
    assign stop_rise   = stop & ~stop_q;
    assign sel_clock   = (sel == '0) || (sel > SW'(NUM_ALARMS));
    assign view_idx    = IW'(sel - SW'(1));
    assign clk_edit    = sel_clock && (edit_rise != 2'b00);
    assign sec_tick    = (pre_q == PW'(CLK_FREQ - 1));
    assign win_d       = sec_tick && !clk_edit;

    always_comb begin
        pre_d    = sec_tick ? '0 : pre_q + 1'b1;
        hr_d     = hr_q;
        min_d    = min_q;
        sec_d    = sec_q;
        al_hr_d  = al_hr_q;
        al_min_d = al_min_q;
        if (clk_edit) begin
            if (edit_rise[0]) begin
                min_d = inc60(min_q);
                sec_d = 7'd0;
            end
            if (edit_rise[1]) hr_d = inc24(hr_q);
        end else if (sec_tick) begin
            sec_d = inc60(sec_q);
            if (sec_q == 7'h59) begin
                min_d = inc60(min_q);
                if (min_q == 7'h59) hr_d = inc24(hr_q);
            end
        end
        if (!sel_clock) begin
            if (edit_rise[0]) al_min_d[view_idx] = inc60(al_min_q[view_idx]);
            if (edit_rise[1]) al_hr_d[view_idx]  = inc24(al_hr_q[view_idx]);
        end
    end

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        match    = 1'b0;
        match_id = '0;
        for (int i = int'(NUM_ALARMS) - 1; i >= 0; i--) begin
            if (alarm_en[i] && al_hr_q[i] == hr_q && al_min_q[i] == min_q) begin
                match    = 1'b1;
                match_id = IW'(i);
            end
        end
        match = match && win_q && (sec_q == 7'd0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q    <= '0;
            hr_q     <= '0;
            min_q    <= '0;
            sec_q    <= '0;
            edit_q   <= '0;
            snooze_q <= 1'b0;
            stop_q   <= 1'b0;
            win_q    <= 1'b0;
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                al_hr_q[i]  <= '0;
                al_min_q[i] <= '0;
            end
        end else begin
            pre_q    <= pre_d;
            hr_q     <= hr_d;
            min_q    <= min_d;
            sec_q    <= sec_d;
            edit_q   <= edit_btns;
            snooze_q <= snooze;
            stop_q   <= stop;
            win_q    <= win_d;
            for (int i = 0; i < int'(NUM_ALARMS); i++) begin
                al_hr_q[i]  <= al_hr_d[i];
                al_min_q[i] <= al_min_d[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            ring_q  <= '0;
            snz_q   <= '0;
            id_q    <= '0;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            snz_q   <= snz_d;
            id_q    <= id_d;
            alarm_q <= alarm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        id_d    = id_q;
        case (state_q)
            StIdle: begin
                if (match) begin
                    state_d = StRing;
                    id_d    = match_id;
                    ring_d  = RW'(RING_SECONDS);
                end
            end
            StRing: begin
                if (!alarm_en[id_q] || stop_rise) begin
                    state_d = StIdle;
                end else if (snooze_rise) begin
                    state_d = StSnooze;
                    snz_d   = ZW'(SNZ_TICKS);
                end else if (sec_tick) begin
                    if (ring_q == RW'(1)) state_d = StIdle;
                    else ring_d = ring_q - 1'b1;
                end
            end
            StSnooze: begin
                if (!alarm_en[id_q] || stop_rise) begin
                    state_d = StIdle;
                end else if (sec_tick) begin
                    if (snz_q == ZW'(1)) begin
                        state_d = StRing;
                        ring_d  = RW'(RING_SECONDS);
                    end else begin
                        snz_d = snz_q - 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        alarm_d = (state_d == StRing);
    end

    assign disp_time = sel_clock ? {hr_q, min_q, sec_q}
                                 : {al_hr_q[view_idx], al_min_q[view_idx], 7'd0};
    assign alarm     = alarm_q;
    assign alarm_id  = id_q;

endmodule
